// File: rtl/wb_trace_checker.sv
// Register-file writeback checker: snoops architectural RF writes and compares
// them in order against a preloaded expected trace, latching a sticky verdict.
module wb_trace_checker #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64,
    parameter int SKIP_X0 = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       exp_we,
    input  logic [$clog2(DEPTH)-1:0]   exp_addr,
    input  logic [REG_AW-1:0]          exp_reg,
    input  logic [XLEN-1:0]            exp_data,
    input  logic [$clog2(DEPTH):0]     exp_len,
    input  logic                       start,
    input  logic                       reg_write,
    input  logic [REG_AW-1:0]          write_reg,
    input  logic [XLEN-1:0]            write_data,
    output logic                       busy,
    output logic                       pass,
    output logic                       fail,
    output logic [1:0]                 err_code,
    output logic [$clog2(DEPTH)-1:0]   err_index,
    output logic [XLEN-1:0]            err_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_DATA    = 2'b01;
    localparam logic [1:0] ERR_REG     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_PASS = 2'b10,
        ST_FAIL = 2'b11
    } state_t;

    state_t            state_r;
    logic [AW-1:0]     idx_r;
    logic [LW-1:0]     len_r;
    logic [TW-1:0]     timer_r;
    logic              busy_r;
    logic              pass_r;
    logic              fail_r;
    logic [1:0]        err_code_r;
    logic [AW-1:0]     err_index_r;
    logic [XLEN-1:0]   err_data_r;

    logic [REG_AW-1:0] mem_reg_r  [DEPTH];
    logic [XLEN-1:0]   mem_data_r [DEPTH];

    logic              accept_s;
    logic [LW-1:0]     len_clamp_s;
    logic              last_s;
    logic              timeout_s;
    logic [REG_AW-1:0] cur_reg_s;
    logic [XLEN-1:0]   cur_data_s;

    // Qualify snooped writes: x0 writes are invisible when SKIP_X0 is set
    always_comb begin
        accept_s = 1'b0;
        if (reg_write) begin
            if ((SKIP_X0 != 0) && (write_reg == {REG_AW{1'b0}})) begin
                accept_s = 1'b0;
            end else begin
                accept_s = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
        end
    end

    // Run length saturates at the trace capacity
    always_comb begin
        len_clamp_s = exp_len;
        if (exp_len > LW'(DEPTH)) begin
            len_clamp_s = LW'(DEPTH);
        end else begin
            len_clamp_s = exp_len;
        end
    end

    // Current expected entry and run-progress flags
    always_comb begin
        cur_reg_s  = mem_reg_r[idx_r];
        cur_data_s = mem_data_r[idx_r];
        last_s     = ({1'b0, idx_r} == (len_r - LW'(1)));
        timeout_s  = (timer_r == TW'(TIMEOUT - 1));
    end

    // Expected-trace storage; frozen while a run is in progress
    always_ff @(posedge clk) begin
        if (exp_we && (state_r != ST_RUN)) begin
            mem_reg_r[exp_addr]  <= exp_reg;
            mem_data_r[exp_addr] <= exp_data;
        end
    end

    // Checker FSM with registered verdict outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= {AW{1'b0}};
            len_r       <= {LW{1'b0}};
            timer_r     <= {TW{1'b0}};
            busy_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_r      <= 1'b0;
            err_code_r  <= ERR_NONE;
            err_index_r <= {AW{1'b0}};
            err_data_r  <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    if (start) begin
                        pass_r      <= 1'b0;
                        fail_r      <= 1'b0;
                        err_code_r  <= ERR_NONE;
                        err_index_r <= {AW{1'b0}};
                        err_data_r  <= {XLEN{1'b0}};
                        len_r       <= len_clamp_s;
                        idx_r       <= {AW{1'b0}};
                        timer_r     <= {TW{1'b0}};
                        if (len_clamp_s == {LW{1'b0}}) begin
                            state_r <= ST_PASS;
                            pass_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= ST_RUN;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        // Register check outranks data check
                        if (write_reg != cur_reg_s) begin
                            state_r     <= ST_FAIL;
                            busy_r      <= 1'b0;
                            fail_r      <= 1'b1;
                            err_code_r  <= ERR_REG;
                            err_index_r <= idx_r;
                            err_data_r  <= write_data;
                        end else if (write_data != cur_data_s) begin
                            state_r     <= ST_FAIL;
                            busy_r      <= 1'b0;
                            fail_r      <= 1'b1;
                            err_code_r  <= ERR_DATA;
                            err_index_r <= idx_r;
                            err_data_r  <= write_data;
                        end else begin
                            timer_r <= {TW{1'b0}};
                            if (last_s) begin
                                state_r <= ST_PASS;
                                busy_r  <= 1'b0;
                                pass_r  <= 1'b1;
                            end else begin
                                idx_r <= idx_r + AW'(1);
                            end
                        end
                    end else if (timeout_s) begin
                        state_r     <= ST_FAIL;
                        busy_r      <= 1'b0;
                        fail_r      <= 1'b1;
                        err_code_r  <= ERR_TIMEOUT;
                        err_index_r <= idx_r;
                        err_data_r  <= {XLEN{1'b0}};
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign pass      = pass_r;
    assign fail      = fail_r;
    assign err_code  = err_code_r;
    assign err_index = err_index_r;
    assign err_data  = err_data_r;

endmodule

// File: doc/wb_trace_checker.md
# wb_trace_checker

Synthesizable register-file writeback checker that sits beside `cpu_uart_top` and snoops the register-file write port (`reg_write`, `write_reg`, `write_data`). It compares each architectural write against a preloaded expected sequence of up to `DEPTH` entries and latches a pass/fail verdict with the failing index and cause. It turns per-instruction directed checks (SLTI, ADDI, …) into on-chip, LED/UART-reportable self-tests, generalised in data width, register-address width, trace depth and timeout.

## Interface
- `XLEN`, 32, data width of `write_data` and expected entries
- `REG_AW`, 5, register index width
- `DEPTH`, 16, max expected entries; power of two, ≥2
- `TIMEOUT`, 64, max idle cycles between accepted writes while running; ≥2
- `SKIP_X0`, 1, when 1, writes with `write_reg==0` are ignored (neither compared nor counted)

Ports:
- `clk`  input  1  single clock; all state on rising edge
- `rst`  input  1  reset, asynchronous, active-low
- `exp_we`  input  1  expected-entry write strobe
- `exp_addr`  input  $clog2(DEPTH)  entry index to write
- `exp_reg`  input  REG_AW  expected destination register
- `exp_data`  input  XLEN  expected write data
- `exp_len`  input  $clog2(DEPTH)+1  number of entries to check, sampled on `start`
- `start`  input  1  one-cycle pulse: arm a check run
- `reg_write`  input  1  snooped RF write enable
- `write_reg`  input  REG_AW  snooped RF destination
- `write_data`  input  XLEN  snooped RF data
- `busy`  output  1  run in progress
- `pass`  output  1  sticky: all `exp_len` entries matched
- `fail`  output  1  sticky: mismatch or timeout
- `err_code`  output  2  00 none, 01 data mismatch, 10 register mismatch, 11 timeout
- `err_index`  output  $clog2(DEPTH)  entry index at failure
- `err_data`  output  XLEN  `write_data` captured at mismatch (0 on timeout)

## Operation
- Storage: `DEPTH` × (`REG_AW`+`XLEN`) array, not reset. Writes via `exp_we` are accepted only in IDLE, PASS and FAIL; ignored while `busy`.
- FSM states: IDLE, RUN, PASS, FAIL.
- IDLE/PASS/FAIL + `start`: clear `pass`, `fail`, `err_*`; load `len`←`exp_len`, `idx`←0, `timer`←0. If `exp_len==0`, go to PASS; else go to RUN.
- RUN, each cycle, with an accepted write = `reg_write && !(SKIP_X0 && write_reg==0)`:
  - Accepted write, `write_reg != entry[idx].reg` → FAIL, code 10 (register check has priority over data).
  - Accepted write, register matches, `write_data != entry[idx].data` → FAIL, code 01.
  - Accepted write, both match → `timer`←0; if `idx==len-1`, go to PASS; else `idx`+1.
  - No accepted write → `timer`+1; at `timer==TIMEOUT-1`, go to FAIL, code 11.
- On FAIL: `err_index`←`idx`, `err_data`←`write_data` (codes 01/10) or 0 (code 11).
- `start` during RUN is ignored.
- `exp_len > DEPTH` is clamped to `DEPTH`.
- Writes after PASS/FAIL are ignored; the verdict holds until the next `start` or reset.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE; `busy`, `pass`, `fail`=0; `err_code`, `err_index`, `err_data`=0; `idx`, `timer`, `len`=0. Reset asserted mid-run aborts immediately with no verdict.
- All outputs are registered. `busy` rises the cycle after `start` and falls in the same cycle `pass` or `fail` rises.
- Verdict latency: `pass`/`fail` is visible one cycle after the clock edge that samples the deciding write, or after the `TIMEOUT`-th consecutive idle cycle.
- `exp_len==0`: `pass` is visible one cycle after `start`; `busy` never rises.
- The write sampled on the same edge as `start` is not checked. Checking begins on the following edge.

## Test plan
- SLTI trace: load {x1,1},{x2,0},{x4,0}, `exp_len`=3, `start`, then drive writes x1=1, x2=0, x4=0 on consecutive cycles → `pass`=1 one cycle after the third write, `err_code`=0.
- Data mismatch: same load; drive x1=1, then x2=5 → `fail`=1, `err_code`=01, `err_index`=1, `err_data`=5; a later x4=0 write leaves the verdict unchanged.
- Register mismatch plus x0 skip: same load; drive x0=7 (ignored), x1=1, then x3=0 → `fail`, `err_code`=10, `err_index`=1.
- Timeout (`TIMEOUT`=64): same load; drive x1=1, then no writes → `fail` with `err_code`=11 and `err_index`=1 exactly 64 cycles after the x1 write; `err_data`=0.
- Control corners: `exp_len`=0 → `pass` one cycle after `start`, `busy` stays 0; `exp_we` during RUN does not alter an entry (proved by a later matching run); `rst` pulled low mid-run → all outputs 0 asynchronously, and a fresh `start` passes.
